// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types and constants for the instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package defs;

  localparam int BIN_DIG = 32;
  localparam int BE_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_t;

  // The memory is word-addressed in practice, so the two byte-offset bits are dropped.
  function automatic logic [BIN_DIG-1:0] word_align(input logic [BIN_DIG-1:0] addr);
    return addr & ~BIN_DIG'(3);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Purpose: saturating count of idle cycles in which a pending fetch lost arbitration.
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none; clear has priority over increment.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] cnt_o
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  // Next count: clear on fetch grant, otherwise count losses up to the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates fetch and dmem requesters onto one single-port memory, one transaction at a time.
// Latency: grant combinational in IDLE; mem_req next cycle; rvalid one cycle after mem_ack.
// Backpressure: a requester is stalled (gnt low) while a transaction is outstanding or it loses arbitration.
module mem_arbiter
  import defs::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               if_req,
  input  logic [BIN_DIG-1:0] if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [BIN_DIG-1:0] if_rdata,
  input  logic               flush,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [BIN_DIG-1:0] dm_addr,
  input  logic [BIN_DIG-1:0] dm_wdata,
  input  logic [BE_W-1:0]    dm_be,
  output logic               dm_gnt,
  output logic               dm_rvalid,
  output logic [BIN_DIG-1:0] dm_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [BIN_DIG-1:0] mem_addr,
  output logic [BIN_DIG-1:0] mem_wdata,
  output logic [BE_W-1:0]    mem_be,
  input  logic               mem_ack,
  input  logic [BIN_DIG-1:0] mem_rdata
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  arb_state_t         state_q;
  logic               mem_req_q, mem_we_q;
  logic [BIN_DIG-1:0] mem_addr_q, mem_wdata_q;
  logic [BE_W-1:0]    mem_be_q;
  logic               if_rvalid_q, dm_rvalid_q;
  logic [BIN_DIG-1:0] if_rdata_q, dm_rdata_q;
  logic               drop_q;
  logic [3:0]         starve_cnt;
  logic               if_win, dm_win;

  // Winner selection in IDLE: dmem first, unless fetch has starved long enough.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (state_q == IDLE) begin
      if (if_req && (!dm_req || (starve_cnt == CNT_MAX))) begin
        if_win = 1'b1;
      end else if (dm_req) begin
        dm_win = 1'b1;
      end
    end
  end

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc_i ((state_q == IDLE) && if_req && !if_win),
    .clr_i (if_win),
    .cnt_o (starve_cnt)
  );

  // Transaction FSM: latch command on grant, hold until ack, then return the response.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_win) begin
            state_q     <= IF_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= word_align(if_addr);
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
            drop_q      <= flush;
          end else if (dm_win) begin
            state_q     <= DM_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= word_align(dm_addr);
            mem_wdata_q <= dm_wdata;
            mem_be_q    <= dm_be;
            drop_q      <= 1'b0;
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            drop_q    <= 1'b0;
            // A flush arriving with the ack still kills this response.
            if (!(drop_q || flush)) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        DM_BUSY: begin
          if (mem_ack) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            dm_rvalid_q <= 1'b1;
            if (!mem_we_q) begin
              dm_rdata_q <= mem_rdata;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_win;
  assign dm_gnt    = dm_win;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter: directed scenarios plus random traffic against a transaction model.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: bench requesters hold req until granted.
module tb_mem_arbiter;
  import defs::*;

  localparam int SMAX = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic               if_req, flush, dm_req, dm_we, mem_ack;
  logic [BIN_DIG-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [BE_W-1:0]    dm_be;
  logic               if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic               mem_req, mem_we;
  logic [BIN_DIG-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [BE_W-1:0]    mem_be;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; flush = 0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release.
  task automatic apply_reset();
    idle_inputs();
    RST = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    @(posedge CLK); #2;
    RST = 0;
    #2;
    n_vec++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin n_err++; $display("FAIL reset_mem: got %h want 0", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}); end
    n_vec++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", {if_rvalid, dm_rvalid}); end
    n_vec++; if ({if_rdata, dm_rdata} !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, dm_rdata}); end
    @(posedge CLK); #1 RST = 1;
    // Released in IDLE: a lone dmem request is granted at once.
    dm_req = 1; dm_addr = 32'h10;
    @(negedge CLK);
    n_vec++; if ({if_gnt, dm_gnt} !== 2'b01) begin n_err++; $display("FAIL reset_first_gnt: got %b want 01", {if_gnt, dm_gnt}); end
    @(posedge CLK); #1 idle_inputs();
  endtask

  task automatic test_single_fetch();
    apply_reset();
    if_req = 1; if_addr = 32'h104;
    @(negedge CLK);
    n_vec++; if ({if_gnt, dm_gnt, mem_req} !== 3'b100) begin n_err++; $display("FAIL fetch_gnt: got %b want 100", {if_gnt, dm_gnt, mem_req}); end
    @(posedge CLK); #1 if_req = 0;
    @(negedge CLK);
    n_vec++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h104}) begin n_err++; $display("FAIL fetch_cmd: got %h want 1_0_f_00000104", {mem_req, mem_we, mem_be, mem_addr}); end
    @(posedge CLK); #1;
    @(posedge CLK); #1 mem_ack = 1; mem_rdata = 32'h00500093;
    @(negedge CLK);
    n_vec++; if ({mem_req, if_rvalid} !== 2'b10) begin n_err++; $display("FAIL fetch_ack_cycle: got %b want 10", {mem_req, if_rvalid}); end
    @(posedge CLK); #1 mem_ack = 0; mem_rdata = '0;
    @(negedge CLK);
    n_vec++; if ({if_rvalid, mem_req} !== 2'b10) begin n_err++; $display("FAIL fetch_rvalid: got %b want 10", {if_rvalid, mem_req}); end
    n_vec++; if (if_rdata !== 32'h00500093) begin n_err++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_vec++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h00500093}) begin n_err++; $display("FAIL fetch_pulse_hold: got %h want 0_00500093", {if_rvalid, if_rdata}); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h2003;
    @(negedge CLK);
    n_vec++; if ({if_gnt, dm_gnt} !== 2'b01) begin n_err++; $display("FAIL simul_gnt: got %b want 01", {if_gnt, dm_gnt}); end
    @(posedge CLK); #1 dm_req = 0; mem_ack = 1; mem_rdata = 32'h0BADF00D;
    @(negedge CLK);
    n_vec++; if ({mem_req, if_gnt, mem_addr} !== {2'b10, 32'h2000}) begin n_err++; $display("FAIL simul_cmd: got %h want 2_00002000", {mem_req, if_gnt, mem_addr}); end
    @(posedge CLK); #1 mem_ack = 0;
    @(negedge CLK);
    n_vec++; if ({if_gnt, dm_gnt, dm_rvalid} !== 3'b101) begin n_err++; $display("FAIL simul_fetch_next: got %b want 101", {if_gnt, dm_gnt, dm_rvalid}); end
    n_vec++; if (dm_rdata !== 32'h0BADF00D) begin n_err++; $display("FAIL simul_dm_rdata: got %h want 0badf00d", dm_rdata); end
    @(posedge CLK); #1 if_req = 0; mem_ack = 1;
    @(negedge CLK);
    n_vec++; if (mem_addr !== 32'h40) begin n_err++; $display("FAIL simul_fetch_addr: got %h want 00000040", mem_addr); end
    @(posedge CLK); #1 idle_inputs();
  endtask

  task automatic test_starvation();
    apply_reset();
    if_req = 1; if_addr = 32'h80; dm_req = 1; dm_addr = 32'h100; mem_ack = 1;
    for (int k = 0; k < SMAX; k++) begin
      @(negedge CLK);
      n_vec++; if ({if_gnt, dm_gnt} !== 2'b01) begin n_err++; $display("FAIL starve_dm_win%0d: got %b want 01", k, {if_gnt, dm_gnt}); end
      @(negedge CLK);
    end
    @(negedge CLK);
    n_vec++; if ({if_gnt, dm_gnt, dm_req} !== 3'b101) begin n_err++; $display("FAIL starve_forced: got %b want 101", {if_gnt, dm_gnt, dm_req}); end
    @(negedge CLK);
    @(negedge CLK);
    n_vec++; if ({if_gnt, dm_gnt} !== 2'b01) begin n_err++; $display("FAIL starve_cleared: got %b want 01", {if_gnt, dm_gnt}); end
    @(posedge CLK); #1 idle_inputs(); mem_ack = 1;
    @(posedge CLK); #1 idle_inputs();
  endtask

  task automatic test_flush();
    apply_reset();
    if_req = 1; if_addr = 32'h200;
    @(posedge CLK); #1 if_req = 0; mem_ack = 1; mem_rdata = 32'hAAAA5555;
    @(posedge CLK); #1 mem_ack = 0;
    @(negedge CLK);
    n_vec++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hAAAA5555}) begin n_err++; $display("FAIL flush_pre_fetch: got %h want 1_aaaa5555", {if_rvalid, if_rdata}); end
    // Flush in the cycle before the ack.
    @(posedge CLK); #1 if_req = 1; if_addr = 32'h204;
    @(posedge CLK); #1 if_req = 0; flush = 1;
    @(posedge CLK); #1 flush = 0; mem_ack = 1; mem_rdata = 32'h55AA55AA;
    @(negedge CLK);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL flush_ack_held: got %b want 1", mem_req); end
    @(posedge CLK); #1 mem_ack = 0; if_req = 1; if_addr = 32'h208;
    @(negedge CLK);
    n_vec++; if ({if_rvalid, if_rdata} !== {1'b0, 32'hAAAA5555}) begin n_err++; $display("FAIL flush_dropped: got %h want 0_aaaa5555", {if_rvalid, if_rdata}); end
    n_vec++; if ({if_gnt, mem_req} !== 2'b10) begin n_err++; $display("FAIL flush_next_gnt: got %b want 10", {if_gnt, mem_req}); end
    @(posedge CLK); #1 if_req = 0; mem_ack = 1; mem_rdata = 32'h12345678;
    @(posedge CLK); #1 mem_ack = 0;
    @(negedge CLK);
    n_vec++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL flush_next_ret: got %h want 1_12345678", {if_rvalid, if_rdata}); end
    // Flush coincident with the ack.
    @(posedge CLK); #1 if_req = 1; if_addr = 32'h20C;
    @(posedge CLK); #1 if_req = 0; mem_ack = 1; flush = 1; mem_rdata = 32'hFFFF0000;
    @(posedge CLK); #1 mem_ack = 0; flush = 0;
    @(negedge CLK);
    n_vec++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h12345678}) begin n_err++; $display("FAIL flush_at_ack: got %h want 0_12345678", {if_rvalid, if_rdata}); end
  endtask

  task automatic test_store();
    apply_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h3005; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    @(negedge CLK);
    n_vec++; if (dm_gnt !== 1'b1) begin n_err++; $display("FAIL store_gnt: got %b want 1", dm_gnt); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1 dm_req = 0; dm_wdata = '0; dm_be = '0; mem_ack = (i == 2); mem_rdata = 32'hCAFEF00D;
      @(negedge CLK);
      n_vec++; if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} !== {2'b11, 4'b0011, 32'hDEADBEEF, 32'h3004}) begin n_err++; $display("FAIL store_cmd%0d: got %h want 3_3_deadbeef_00003004", i, {mem_req, mem_we, mem_be, mem_wdata, mem_addr}); end
    end
    @(posedge CLK); #1 mem_ack = 0;
    @(negedge CLK);
    n_vec++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL store_done: got %h want 1_00000000", {dm_rvalid, dm_rdata}); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    @(posedge CLK); #1 dm_req = 0;
    @(negedge CLK);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", mem_req); end
    @(posedge CLK); #1 RST = 0;
    #1;
    n_vec++; if ({mem_req, mem_addr, dm_rvalid} !== '0) begin n_err++; $display("FAIL rstmid_async: got %h want 0", {mem_req, mem_addr, dm_rvalid}); end
    @(posedge CLK); #1 RST = 1; mem_ack = 1; mem_rdata = 32'h77777777; dm_req = 1; dm_addr = 32'h404;
    @(negedge CLK);
    n_vec++; if ({dm_gnt, dm_rvalid} !== 2'b10) begin n_err++; $display("FAIL rstmid_regnt: got %b want 10", {dm_gnt, dm_rvalid}); end
    @(posedge CLK); #1 dm_req = 0; mem_ack = 0;
    @(negedge CLK);
    n_vec++; if ({dm_rvalid, mem_req, mem_addr} !== {2'b01, 32'h404}) begin n_err++; $display("FAIL rstmid_cmd: got %h want 1_00000404", {dm_rvalid, mem_req, mem_addr}); end
    @(posedge CLK); #1 mem_ack = 1; mem_rdata = 32'h13579BDF;
    @(posedge CLK); #1 mem_ack = 0;
    @(negedge CLK);
    n_vec++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h13579BDF}) begin n_err++; $display("FAIL rstmid_done: got %h want 1_13579bdf", {dm_rvalid, dm_rdata}); end
  endtask

  // Random traffic vs. a transaction-level model: one outstanding job, rules applied per cycle.
  task automatic test_random();
    bit               m_busy = 0, m_own_if = 0, m_drop = 0, m_we = 0;
    bit               m_if_rv = 0, m_dm_rv = 0, exp_if, exp_dm;
    bit               got_if = 0, got_dm = 0;
    int               m_starve = 0;
    logic [31:0]      m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
    logic [3:0]       m_be = '0;
    apply_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!if_req || got_if) begin if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom; end
      if (!dm_req || got_dm) begin
        dm_req = ($urandom_range(0, 2) != 0); dm_we = $urandom_range(0, 1);
        dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 5) == 0);
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      exp_if = !m_busy && if_req && (!dm_req || m_starve == SMAX);
      exp_dm = !m_busy && dm_req && !exp_if;
      @(negedge CLK);
      n_vec++; if ({if_gnt, dm_gnt} !== {exp_if, exp_dm}) begin n_err++; $display("FAIL rnd_gnt c%0d: got %b want %b", cyc, {if_gnt, dm_gnt}, {exp_if, exp_dm}); end
      n_vec++; if (mem_req !== m_busy) begin n_err++; $display("FAIL rnd_mem_req c%0d: got %b want %b", cyc, mem_req, m_busy); end
      if (m_busy) begin
        n_vec++; if ({mem_we, mem_be, mem_addr} !== {m_we, m_be, m_addr}) begin n_err++; $display("FAIL rnd_cmd c%0d: got %h want %h", cyc, {mem_we, mem_be, mem_addr}, {m_we, m_be, m_addr}); end
        if (!m_own_if) begin
          n_vec++; if (mem_wdata !== m_wdata) begin n_err++; $display("FAIL rnd_wdata c%0d: got %h want %h", cyc, mem_wdata, m_wdata); end
        end
      end
      n_vec++; if ({if_rvalid, dm_rvalid} !== {m_if_rv, m_dm_rv}) begin n_err++; $display("FAIL rnd_rvalid c%0d: got %b want %b", cyc, {if_rvalid, dm_rvalid}, {m_if_rv, m_dm_rv}); end
      n_vec++; if ({if_rdata, dm_rdata} !== {m_if_rdata, m_dm_rdata}) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, {if_rdata, dm_rdata}, {m_if_rdata, m_dm_rdata}); end
      got_if = exp_if;
      got_dm = exp_dm;
      m_if_rv = 0;
      m_dm_rv = 0;
      if (m_busy) begin
        if (m_own_if) begin
          if (mem_ack) begin
            m_busy = 0;
            if (!(m_drop || flush)) begin m_if_rv = 1; m_if_rdata = mem_rdata; end
          end else if (flush) begin
            m_drop = 1;
          end
        end else if (mem_ack) begin
          m_busy = 0; m_dm_rv = 1;
          if (!m_we) m_dm_rdata = mem_rdata;
        end
      end else if (exp_if) begin
        m_busy = 1; m_own_if = 1; m_addr = if_addr & 32'hFFFF_FFFC;
        m_we = 0; m_be = 4'hF; m_drop = flush; m_starve = 0;
      end else if (exp_dm) begin
        m_busy = 1; m_own_if = 0; m_addr = dm_addr & 32'hFFFF_FFFC;
        m_we = dm_we; m_wdata = dm_wdata; m_be = dm_be; m_drop = 0;
        if (if_req && m_starve < SMAX) m_starve++;
      end
      @(posedge CLK); #1;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
